// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-master data-RAM arbiter: CPU port, external (loader/DMA)
// port and the single-ported RAM port. The arbiter uses the slave view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 14
);

  // CPU (pipeline MEM stage) port
  logic              cpu_req;
  logic [3:0]        cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [31:0]       cpu_rdata;

  // External master port
  logic              ext_req;
  logic [3:0]        ext_we;
  logic [31:0]       ext_addr;
  logic [31:0]       ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [31:0]       ext_rdata;

  // RAM port; ram_rdata is valid the cycle after an access is issued
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-ported data RAM: CPU has priority, the external
// master wins after STARVE_MAX consecutive lost cycles; read responses are routed back.
//
// Handshake: a port presents req (with we/addr/wdata) and holds it until issued.
// The CPU is issued in any cycle where cpu_req=1 and cpu_stall=0; the external
// master is issued in any cycle where ext_gnt=1. A read (we==0) issued in cycle N
// returns exactly one rvalid pulse with its data in cycle N+1; writes never respond.
module mem_arbiter #(
  parameter  int ADDR_W     = 14,
  parameter  int STARVE_MAX = 4,
  localparam int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             clrn,
  mem_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] dbg_starve_cnt_o,
  output logic [1:0]       dbg_resp_owner_o
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  localparam logic [CNT_W-1:0] STARVE_FULL = CNT_W'(STARVE_MAX);

  owner_e           resp_owner_q, resp_owner_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic             starve_full;
  logic             ext_issued;
  logic             cpu_issued;
  logic [3:0]       issue_we;

  // Only the word-address slice of each byte address reaches the RAM.
  logic             addr_unused;
  assign addr_unused = ^{bus.cpu_addr, bus.ext_addr};

  // ---------------------------------------------------------------------------
  // Issue decision: combinational on current requests and registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_full = (starve_cnt_q == STARVE_FULL);
    ext_issued  = bus.ext_req & (~bus.cpu_req | starve_full);
    cpu_issued  = bus.cpu_req & ~ext_issued;
  end

  // RAM port mux; with nothing issued the CPU values pass through with we forced low.
  always_comb begin
    bus.ram_addr  = bus.cpu_addr[ADDR_W+1:2];
    bus.ram_wdata = bus.cpu_wdata;
    issue_we      = 4'b0000;
    if (ext_issued) begin
      bus.ram_addr  = bus.ext_addr[ADDR_W+1:2];
      bus.ram_wdata = bus.ext_wdata;
      issue_we      = bus.ext_we;
    end else if (cpu_issued) begin
      issue_we      = bus.cpu_we;
    end
    bus.ram_we = issue_we;
  end

  always_comb begin
    bus.cpu_stall = bus.cpu_req & ~cpu_issued;
    bus.ext_gnt   = bus.ext_req & ext_issued;
  end

  // ---------------------------------------------------------------------------
  // Starvation counter: counts consecutive cycles ext wanted the RAM and lost
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.ext_req || ext_issued) begin
      starve_cnt_d = '0;
    end else if (!starve_full) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Response owner FSM: remembers who issued a read last cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    resp_owner_d = OWN_NONE;
    if (cpu_issued && (bus.cpu_we == 4'b0000)) begin
      resp_owner_d = OWN_CPU;
    end else if (ext_issued && (bus.ext_we == 4'b0000)) begin
      resp_owner_d = OWN_EXT;
    end
  end

  // A read in flight when reset hits is dropped because the owner clears here.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      resp_owner_q <= OWN_NONE;
      starve_cnt_q <= '0;
    end else begin
      resp_owner_q <= resp_owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.cpu_rvalid = (resp_owner_q == OWN_CPU);
    bus.ext_rvalid = (resp_owner_q == OWN_EXT);
    bus.cpu_rdata  = bus.cpu_rvalid ? bus.ram_rdata : 32'h0000_0000;
    bus.ext_rdata  = bus.ext_rvalid ? bus.ram_rdata : 32'h0000_0000;
  end

  assign dbg_starve_cnt_o = starve_cnt_q;
  assign dbg_resp_owner_o = resp_owner_q;

  // ---------------------------------------------------------------------------
  // Embedded properties
  // ---------------------------------------------------------------------------
  a_one_rvalid : assert property (@(posedge clk) disable iff (!clrn)
    !(bus.cpu_rvalid && bus.ext_rvalid));

  a_starve_bound : assert property (@(posedge clk) disable iff (!clrn)
    starve_cnt_q <= STARVE_FULL);

  a_one_issue : assert property (@(posedge clk) disable iff (!clrn)
    !(cpu_issued && ext_issued));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: small behavioural RAM, hand-computed
// expectations, and a queue of expected read data for the alternating-port sequence.
module tb_mem_arbiter;

  localparam int ADDR_W = 14;

  logic       clk;
  logic       clrn;
  logic [2:0] dbg_starve_cnt;
  logic [1:0] dbg_resp_owner;

  int checks;
  int fails;

  logic [31:0] mem [0:255];
  logic [31:0] exp_q [$];

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .STARVE_MAX(4)
  ) dut (
    .clk             (clk),
    .clrn            (clrn),
    .bus             (bus),
    .dbg_starve_cnt_o(dbg_starve_cnt),
    .dbg_resp_owner_o(dbg_resp_owner)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model: one-cycle read latency, byte-lane writes ----------------
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bus.ram_we[b]) mem[bus.ram_addr[7:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
    bus.ram_rdata <= mem[bus.ram_addr[7:0]];
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 4'b0000;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    bus.ext_req   = 1'b0;
    bus.ext_we    = 4'b0000;
    bus.ext_addr  = 32'h0;
    bus.ext_wdata = 32'h0;
  endtask

  task automatic cpu_drive(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic ext_drive(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.ext_req   = 1'b1;
    bus.ext_we    = we;
    bus.ext_addr  = addr;
    bus.ext_wdata = wdata;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] exp_d;
    checks = 0;
    fails  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h41] = 32'hDEAD_BEEF;
    mem[5]     = 32'hA5A5_0005;
    mem[9]     = 32'h9999_0009;
    bus.ram_rdata = 32'h0;
    clrn = 1'b0;
    idle();

    // Reset state
    #2;
    check("rst_cpu_rvalid", {31'h0, bus.cpu_rvalid}, 32'h0);
    check("rst_ext_rvalid", {31'h0, bus.ext_rvalid}, 32'h0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    check("rst_ext_rdata", bus.ext_rdata, 32'h0);
    check("rst_starve", {29'h0, dbg_starve_cnt}, 32'h0);
    check("rst_owner", {30'h0, dbg_resp_owner}, 32'h0);
    check("rst_ram_we", {28'h0, bus.ram_we}, 32'h0);
    #10 clrn = 1'b1;
    cyc();

    // CPU read of word 0x41
    cpu_drive(4'b0000, 32'h0000_0104, 32'h0);
    #1;
    check("rd_ram_addr", {18'h0, bus.ram_addr}, 32'h41);
    check("rd_ram_we", {28'h0, bus.ram_we}, 32'h0);
    check("rd_stall", {31'h0, bus.cpu_stall}, 32'h0);
    cyc();
    idle();
    #1;
    check("rd_cpu_rvalid", {31'h0, bus.cpu_rvalid}, 32'h1);
    check("rd_cpu_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
    check("rd_ext_rvalid", {31'h0, bus.ext_rvalid}, 32'h0);
    cyc();
    #1;
    check("rd_pulse_end", {31'h0, bus.cpu_rvalid}, 32'h0);
    check("rd_rdata_zero", bus.cpu_rdata, 32'h0);

    // CPU partial write: lanes 0/1 at word 2
    cyc();
    cpu_drive(4'b0011, 32'h0000_0008, 32'h1234_5678);
    #1;
    check("wr_ram_we", {28'h0, bus.ram_we}, 32'h3);
    check("wr_ram_addr", {18'h0, bus.ram_addr}, 32'h2);
    check("wr_ram_wdata", bus.ram_wdata, 32'h1234_5678);
    cyc();
    idle();
    #1;
    check("wr_no_rvalid", {30'h0, bus.ext_rvalid, bus.cpu_rvalid}, 32'h0);
    check("wr_ram_we_off", {28'h0, bus.ram_we}, 32'h0);
    check("wr_mem_lanes", mem[2], 32'h0000_5678);

    // Both requesting for 6 cycles: ext wins on the fifth
    cyc();
    cpu_drive(4'b0000, 32'h0000_0104, 32'h0);
    ext_drive(4'b0000, 32'h0000_0024, 32'h0);
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("arb%0d_ext_gnt", i), {31'h0, bus.ext_gnt}, {31'h0, i == 4});
      check($sformatf("arb%0d_cpu_stall", i), {31'h0, bus.cpu_stall}, {31'h0, i == 4});
      check($sformatf("arb%0d_starve", i), {29'h0, dbg_starve_cnt}, (i <= 4) ? i : 0);
      check($sformatf("arb%0d_cpu_rvalid", i), {31'h0, bus.cpu_rvalid}, {31'h0, (i >= 1) && (i != 5)});
      check($sformatf("arb%0d_ext_rvalid", i), {31'h0, bus.ext_rvalid}, {31'h0, i == 5});
      if (i == 5) check("arb5_ext_rdata", bus.ext_rdata, 32'h9999_0009);
      cyc();
    end
    idle();
    cyc();

    // Alternating CPU word 5 / ext word 9 reads, back to back
    for (int k = 0; k < 5; k++) begin
      idle();
      if (k < 4) begin
        if (k % 2 == 0) begin
          cpu_drive(4'b0000, 32'h0000_0014, 32'h0);
          exp_q.push_back(32'hA5A5_0005);
        end else begin
          ext_drive(4'b0000, 32'h0000_0024, 32'h0);
          exp_q.push_back(32'h9999_0009);
        end
      end
      #1;
      if (k < 4) begin
        check($sformatf("alt%0d_issue", k), {30'h0, bus.ext_gnt, bus.cpu_stall}, (k % 2 == 0) ? 32'h0 : 32'h2);
      end
      if (k > 0) begin
        exp_d = exp_q.pop_front();
        if ((k - 1) % 2 == 0) begin
          check($sformatf("alt%0d_cpu_rvalid", k), {31'h0, bus.cpu_rvalid}, 32'h1);
          check($sformatf("alt%0d_cpu_rdata", k), bus.cpu_rdata, exp_d);
          check($sformatf("alt%0d_ext_quiet", k), {31'h0, bus.ext_rvalid}, 32'h0);
        end else begin
          check($sformatf("alt%0d_ext_rvalid", k), {31'h0, bus.ext_rvalid}, 32'h1);
          check($sformatf("alt%0d_ext_rdata", k), bus.ext_rdata, exp_d);
          check($sformatf("alt%0d_cpu_quiet", k), {31'h0, bus.cpu_rvalid}, 32'h0);
        end
      end
      cyc();
    end
    idle();
    check("alt_queue_empty", exp_q.size(), 32'h0);
    cyc();

    // Ext read issued, then reset before the response edge
    ext_drive(4'b0000, 32'h0000_0024, 32'h0);
    #1;
    check("rst_mid_ext_gnt", {31'h0, bus.ext_gnt}, 32'h1);
    #2;
    clrn = 1'b0;
    idle();
    cpu_drive(4'b1111, 32'h0000_0040, 32'h0);
    #1;
    check("rst_mid_ext_rvalid", {31'h0, bus.ext_rvalid}, 32'h0);
    check("rst_mid_ext_rdata", bus.ext_rdata, 32'h0);
    check("rst_mid_owner", {30'h0, dbg_resp_owner}, 32'h0);
    check("rst_mid_ram_we", {28'h0, bus.ram_we}, 32'hF);
    check("rst_mid_ram_addr", {18'h0, bus.ram_addr}, 32'h10);
    check("rst_mid_stall", {31'h0, bus.cpu_stall}, 32'h0);
    cyc();
    idle();
    check("rst_hold_ext_rvalid", {31'h0, bus.ext_rvalid}, 32'h0);
    #2 clrn = 1'b1;
    cyc();
    check("post_rst_ext_rvalid", {31'h0, bus.ext_rvalid}, 32'h0);
    check("post_rst_cpu_rvalid", {31'h0, bus.cpu_rvalid}, 32'h0);

    // Starvation count restarts after ext drops its request for a cycle
    cpu_drive(4'b0000, 32'h0000_0104, 32'h0);
    for (int j = 0; j < 3; j++) begin
      ext_drive(4'b0000, 32'h0000_0024, 32'h0);
      #1;
      check($sformatf("stv_a%0d_gnt", j), {31'h0, bus.ext_gnt}, 32'h0);
      check($sformatf("stv_a%0d_cnt", j), {29'h0, dbg_starve_cnt}, j);
      cyc();
    end
    bus.ext_req = 1'b0;
    #1;
    check("stv_gap_cnt", {29'h0, dbg_starve_cnt}, 32'h3);
    check("stv_gap_gnt", {31'h0, bus.ext_gnt}, 32'h0);
    cyc();
    for (int j = 0; j < 5; j++) begin
      bus.ext_req = 1'b1;
      #1;
      check($sformatf("stv_b%0d_gnt", j), {31'h0, bus.ext_gnt}, {31'h0, j == 4});
      check($sformatf("stv_b%0d_cnt", j), {29'h0, dbg_starve_cnt}, j);
      cyc();
    end
    idle();
    #1;
    check("stv_end_cnt", {29'h0, dbg_starve_cnt}, 32'h0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
